// File: rtl/pool_pkg.sv
// Shared helpers for the pooled-row serializer: clog2, row/frame geometry
// and the element-slice macro used to pick one element out of a packed row.

`ifndef POOL_ELEM
`define POOL_ELEM(k, w) ((k) * (w)) +: (w)
`endif

package pool_pkg;

  // Ceiling log2, returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

  // Elements per pooled row: half the input width times the channel count.
  function automatic int row_elems(input int w, input int d);
    return (w / 2) * d;
  endfunction

  // Rows per pooled frame: half the input height.
  function automatic int rows_per_frame(input int h);
    return h / 2;
  endfunction

endpackage

// File: rtl/row_fifo.sv
// Generic register FIFO holding whole rows. A push while full is taken
// when a pop happens in the same cycle, since the head slot frees at that
// edge. Pointers wrap naturally; a separate count tells full from empty.

module row_fifo
  import pool_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int PW = clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_pop;
  logic             w_push;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == {CW{1'b0}});
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_head  = r_mem[r_rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + {{(PW-1){1'b0}}, 1'b1};
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + {{(PW-1){1'b0}}, 1'b1};
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   r_count <= r_count - {{(CW-1){1'b0}}, 1'b1};
        default: r_count <= r_count;
      endcase
    end
  end

  // Row storage; contents are don't-care after reset so no reset branch.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

endmodule

// File: rtl/pool_row_serializer.sv
// Serializes pooled rows into a one-element-per-transfer valid/ready stream
// and flags the last element of every row and every frame. Rows arriving
// while the row FIFO is full (and not freeing a slot) are dropped and
// reported through the sticky overflow_o.
// Optional: define POOL_SER_FRAME_CNT_EN to add the 16-bit frame_cnt_o.

module pool_row_serializer
  import pool_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int D          = 1,
  parameter int H          = 24,
  parameter int W          = 24,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [(W/2)*D*DATA_BITS-1:0]   row_data_i,
  input  logic                           valid_i,
  output logic [DATA_BITS-1:0]           data_o,
  output logic                           valid_o,
  input  logic                           ready_i,
  output logic                           row_last_o,
  output logic                           last_o,
  output logic                           overflow_o
`ifdef POOL_SER_FRAME_CNT_EN
  ,
  output logic [15:0]                    frame_cnt_o
`endif
);

  localparam int N        = row_elems(W, D);
  localparam int R        = rows_per_frame(H);
  localparam int ROW_BITS = N * DATA_BITS;
  localparam int EW       = (N > 1) ? clog2(N) : 1;
  localparam int RW       = (R > 1) ? clog2(R) : 1;

  logic [EW-1:0]       r_elem_cnt;
  logic [RW-1:0]       r_row_cnt;
  logic                r_overflow;
  logic                w_full;
  logic                w_empty;
  logic [ROW_BITS-1:0] w_head;
  logic                w_transfer;
  logic                w_elem_last;
  logic                w_row_last;
  logic                w_pop;
  logic [DATA_BITS-1:0] w_data;

  assign valid_o     = ~w_empty;
  assign w_transfer  = valid_o & ready_i;
  assign w_elem_last = (r_elem_cnt == EW'(N - 1));
  assign w_row_last  = (r_row_cnt == RW'(R - 1));
  assign w_pop       = w_transfer & w_elem_last;
  assign row_last_o  = valid_o & w_elem_last;
  assign last_o      = row_last_o & w_row_last;
  assign overflow_o  = r_overflow;
  assign data_o      = w_data;

  row_fifo #(
    .WIDTH (ROW_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_row_fifo (
    .clk     (clk),
    .i_rst_n (reset),
    .i_push  (valid_i),
    .i_pop   (w_pop),
    .i_data  (row_data_i),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  // Pick the current element from the head row; drive zero while idle.
  always_comb begin
    w_data = {DATA_BITS{1'b0}};
    if (!w_empty) begin
      w_data = w_head[`POOL_ELEM(r_elem_cnt, DATA_BITS)];
    end else begin
      w_data = {DATA_BITS{1'b0}};
    end
  end

  // Element/row position counters advance on each accepted transfer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_elem_cnt <= {EW{1'b0}};
      r_row_cnt  <= {RW{1'b0}};
    end else if (w_transfer) begin
      if (w_elem_last) begin
        r_elem_cnt <= {EW{1'b0}};
        r_row_cnt  <= w_row_last ? {RW{1'b0}} : (r_row_cnt + {{(RW-1){1'b0}}, 1'b1});
      end else begin
        r_elem_cnt <= r_elem_cnt + {{(EW-1){1'b0}}, 1'b1};
      end
    end
  end

  // Sticky drop flag: full FIFO whose head is not freeing a slot this cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overflow <= 1'b0;
    end else if (valid_i & w_full & ~w_pop) begin
      r_overflow <= 1'b1;
    end
  end

`ifdef POOL_SER_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;
  assign frame_cnt_o = r_frame_cnt;

  // Count completed frames, wrapping at 16 bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_frame_cnt <= 16'd0;
    end else if (w_transfer & last_o) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pool_row_serializer.sv
// Self-checking bench for pool_row_serializer. The reference model keeps a
// queue of accepted rows and a running transfer count; element and row
// positions are derived from that count arithmetically.

module tb_pool_row_serializer;

  localparam int DB    = 8;
  localparam int D     = 1;
  localparam int H     = 24;
  localparam int W     = 24;
  localparam int DEPTH = 2;
  localparam int N     = (W / 2) * D;
  localparam int R     = H / 2;
  localparam int RB    = N * DB;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [RB-1:0] row_data_i = '0;
  logic          valid_i = 1'b0;
  logic          ready_i = 1'b0;
  logic [DB-1:0] data_o;
  logic          valid_o;
  logic          row_last_o;
  logic          last_o;
  logic          overflow_o;
`ifdef POOL_SER_FRAME_CNT_EN
  logic [15:0]   frame_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [RB-1:0] mq[$];
  int t_total;
  bit m_ovf;
  int m_frames;

  pool_row_serializer #(
    .DATA_BITS (DB), .D (D), .H (H), .W (W), .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .row_data_i (row_data_i),
    .valid_i    (valid_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .row_last_o (row_last_o),
    .last_o     (last_o),
    .overflow_o (overflow_o)
`ifdef POOL_SER_FRAME_CNT_EN
    ,
    .frame_cnt_o (frame_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  function automatic bit exp_valid();
    return mq.size() > 0;
  endfunction

  function automatic logic [DB-1:0] exp_data();
    logic [RB-1:0] h;
    if (mq.size() == 0) return '0;
    h = mq[0];
    return h[(t_total % N) * DB +: DB];
  endfunction

  function automatic bit exp_rl();
    return exp_valid() && ((t_total % N) == N - 1);
  endfunction

  function automatic bit exp_last();
    return exp_rl() && (((t_total / N) % R) == R - 1);
  endfunction

  function automatic logic [11:0] exp_vec();
    return {exp_valid(), exp_data(), exp_rl(), exp_last(), m_ovf};
  endfunction

  function automatic logic [RB-1:0] rand_row();
    logic [RB-1:0] r;
    for (int i = 0; i < N; i++) r[i * DB +: DB] = DB'($urandom);
    return r;
  endfunction

  function automatic logic [RB-1:0] ramp_row(input int base);
    logic [RB-1:0] r;
    for (int i = 0; i < N; i++) r[i * DB +: DB] = DB'(base + i);
    return r;
  endfunction

  task automatic model_clear();
    mq.delete();
    t_total  = 0;
    m_ovf    = 1'b0;
    m_frames = 0;
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then
  // settle 1 time unit past the edge.
  task automatic step(input bit v, input logic [RB-1:0] row, input bit rdy);
    bit xfer, fin, acc;
    valid_i    = v;
    row_data_i = row;
    ready_i    = rdy;
    xfer = exp_valid() && rdy;
    fin  = xfer && ((t_total % N) == N - 1);
    acc  = v && ((mq.size() < DEPTH) || fin);
    if (v && !acc) m_ovf = 1'b1;
    if (xfer) begin
      if (exp_last()) m_frames++;
      t_total++;
      if (fin) void'(mq.pop_front());
    end
    if (acc) mq.push_back(row);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    valid_i = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", valid_o); end
    checks++; if (data_o !== 8'd0) begin errors++; $display("FAIL reset_data got=%h want=00", data_o); end
    checks++; if (row_last_o !== 1'b0) begin errors++; $display("FAIL reset_row_last got=%b want=0", row_last_o); end
    checks++; if (last_o !== 1'b0) begin errors++; $display("FAIL reset_last got=%b want=0", last_o); end
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b want=0", overflow_o); end
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_row();
    do_reset();
    step(1'b1, ramp_row(1), 1'b1);
    for (int c = 1; c <= N + 1; c++) begin
      checks++;
      if ({valid_o, data_o, row_last_o, last_o, overflow_o} !== exp_vec()) begin
        errors++; $display("FAIL single_row cyc=%0d got=%h want=%h", c, {valid_o, data_o, row_last_o, last_o, overflow_o}, exp_vec());
      end
      if (c <= N) begin
        checks++;
        if (data_o !== DB'(c) || valid_o !== 1'b1 || row_last_o !== (c == N)) begin
          errors++; $display("FAIL single_row_elem cyc=%0d got=%0d/%b want=%0d/%b", c, data_o, row_last_o, c, (c == N));
        end
      end else begin
        checks++;
        if (valid_o !== 1'b0) begin errors++; $display("FAIL single_row_idle got=%b want=0", valid_o); end
      end
      step(1'b0, '0, 1'b1);
    end
  endtask

  task automatic test_backpressure();
    logic [DB-1:0] got[$];
    int stalls;
    bit rdy;
    do_reset();
    stalls = 0;
    step(1'b1, ramp_row(1), 1'b1);
    for (int c = 0; c < 24; c++) begin
      rdy = !(exp_data() == 8'd3 && stalls < 4);
      if (!rdy) begin
        stalls++;
        checks++;
        if (data_o !== 8'd3 || valid_o !== 1'b1) begin
          errors++; $display("FAIL backpressure_hold got=%0d/%b want=3/1", data_o, valid_o);
        end
      end
      checks++;
      if ({valid_o, data_o, row_last_o, last_o, overflow_o} !== exp_vec()) begin
        errors++; $display("FAIL backpressure_stream cyc=%0d got=%h want=%h", c, {valid_o, data_o, row_last_o, last_o, overflow_o}, exp_vec());
      end
      if (valid_o && rdy) got.push_back(data_o);
      step(1'b0, '0, rdy);
    end
    checks++;
    if (got.size() != N || stalls != 4) begin
      errors++; $display("FAIL backpressure_count got=%0d/%0d want=%0d/4", got.size(), stalls, N);
    end else begin
      for (int i = 0; i < N; i++) begin
        checks++;
        if (got[i] !== DB'(i + 1)) begin errors++; $display("FAIL backpressure_order idx=%0d got=%0d want=%0d", i, got[i], i + 1); end
      end
    end
  endtask

  task automatic test_overflow();
    logic [RB-1:0] a, b, c;
    logic [DB-1:0] got[$];
    logic [DB-1:0] want[$];
    a = rand_row(); b = rand_row(); c = rand_row();
    // Case 1: third row arrives with no slot freeing -> dropped.
    do_reset();
    step(1'b1, a, 1'b0);
    step(1'b1, b, 1'b0);
    step(1'b1, c, 1'b0);
    checks++;
    if (overflow_o !== 1'b1) begin errors++; $display("FAIL overflow_set got=%b want=1", overflow_o); end
    for (int k = 0; k < 2 * N + 4; k++) begin
      checks++;
      if ({valid_o, data_o, row_last_o, last_o, overflow_o} !== exp_vec()) begin
        errors++; $display("FAIL overflow_stream cyc=%0d got=%h want=%h", k, {valid_o, data_o, row_last_o, last_o, overflow_o}, exp_vec());
      end
      if (valid_o) got.push_back(data_o);
      step(1'b0, '0, 1'b1);
    end
    for (int i = 0; i < N; i++) want.push_back(a[i * DB +: DB]);
    for (int i = 0; i < N; i++) want.push_back(b[i * DB +: DB]);
    checks++;
    if (got != want) begin errors++; $display("FAIL overflow_ab_order got_len=%0d want_len=%0d", got.size(), want.size()); end
    // Case 2: third row lands on the final-element transfer of A -> accepted.
    got.delete();
    want.delete();
    do_reset();
    step(1'b1, a, 1'b0);
    step(1'b1, b, 1'b0);
    for (int k = 0; k < 3 * N + 4; k++) begin
      checks++;
      if ({valid_o, data_o, row_last_o, last_o, overflow_o} !== exp_vec()) begin
        errors++; $display("FAIL overflow_edge_stream cyc=%0d got=%h want=%h", k, {valid_o, data_o, row_last_o, last_o, overflow_o}, exp_vec());
      end
      if (valid_o) got.push_back(data_o);
      step(k == N - 1, c, 1'b1);
    end
    checks++;
    if (overflow_o !== 1'b0) begin errors++; $display("FAIL overflow_edge_flag got=%b want=0", overflow_o); end
    for (int i = 0; i < N; i++) want.push_back(a[i * DB +: DB]);
    for (int i = 0; i < N; i++) want.push_back(b[i * DB +: DB]);
    for (int i = 0; i < N; i++) want.push_back(c[i * DB +: DB]);
    checks++;
    if (got != want) begin errors++; $display("FAIL overflow_edge_order got_len=%0d want_len=%0d", got.size(), want.size()); end
  endtask

  task automatic test_frame();
    logic [RB-1:0] rows [R + 1];
    int xfers, last_seen, last_at;
    do_reset();
    for (int j = 0; j <= R; j++) rows[j] = rand_row();
    xfers = 0; last_seen = 0; last_at = -1;
    for (int cyc = 0; cyc < (R + 1) * N + 5; cyc++) begin
      checks++;
      if ({valid_o, data_o, row_last_o, last_o, overflow_o} !== exp_vec()) begin
        errors++; $display("FAIL frame_stream cyc=%0d got=%h want=%h", cyc, {valid_o, data_o, row_last_o, last_o, overflow_o}, exp_vec());
      end
      if (valid_o) begin
        xfers++;
        if (last_o) begin last_seen++; last_at = xfers; end
        if (xfers == R * N + 1) begin
          checks++;
          if (data_o !== rows[R][DB-1:0] || row_last_o !== 1'b0) begin
            errors++; $display("FAIL frame_new_first got=%h want=%h", data_o, rows[R][DB-1:0]);
          end
        end
      end
      step((cyc % N == 0) && (cyc < (R + 1) * N), rows[cyc / N], 1'b1);
    end
    checks++;
    if (last_seen != 1 || last_at != R * N || xfers != (R + 1) * N) begin
      errors++; $display("FAIL frame_last got=%0d@%0d/%0d want=1@%0d/%0d", last_seen, last_at, xfers, R * N, (R + 1) * N);
    end
`ifdef POOL_SER_FRAME_CNT_EN
    checks++;
    if (frame_cnt_o !== 16'd1) begin errors++; $display("FAIL frame_cnt got=%0d want=1", frame_cnt_o); end
`endif
  endtask

  task automatic test_midrow_reset();
    logic [RB-1:0] nr;
    int guard;
    do_reset();
    step(1'b1, ramp_row(1), 1'b1);
    guard = 0;
    while (exp_data() != 8'd5 && guard < 20) begin
      step(1'b0, '0, 1'b1);
      guard++;
    end
    checks++;
    if (data_o !== 8'd5) begin errors++; $display("FAIL midrow_reach got=%0d want=5", data_o); end
    reset = 1'b0;
    #2;
    model_clear();
    checks++;
    if (valid_o !== 1'b0 || data_o !== 8'd0) begin
      errors++; $display("FAIL midrow_async got=%b/%0d want=0/0", valid_o, data_o);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    nr = rand_row();
    step(1'b1, nr, 1'b1);
    checks++;
    if (data_o !== nr[DB-1:0] || valid_o !== 1'b1) begin
      errors++; $display("FAIL midrow_restart got=%h/%b want=%h/1", data_o, valid_o, nr[DB-1:0]);
    end
    for (int k = 0; k < N + 2; k++) begin
      checks++;
      if ({valid_o, data_o, row_last_o, last_o, overflow_o} !== exp_vec()) begin
        errors++; $display("FAIL midrow_stream cyc=%0d got=%h want=%h", k, {valid_o, data_o, row_last_o, last_o, overflow_o}, exp_vec());
      end
      step(1'b0, '0, 1'b1);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 2500; k++) begin
      checks++;
      if ({valid_o, data_o, row_last_o, last_o, overflow_o} !== exp_vec()) begin
        errors++; $display("FAIL random_stream cyc=%0d got=%h want=%h", k, {valid_o, data_o, row_last_o, last_o, overflow_o}, exp_vec());
      end
`ifdef POOL_SER_FRAME_CNT_EN
      checks++;
      if (frame_cnt_o !== 16'(m_frames)) begin errors++; $display("FAIL random_frame_cnt got=%0d want=%0d", frame_cnt_o, m_frames); end
`endif
      step($urandom_range(0, 12) == 0, rand_row(), $urandom_range(0, 3) != 0);
    end
  endtask

  initial begin
    test_reset();
    test_single_row();
    test_backpressure();
    test_overflow();
    test_frame();
    test_midrow_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pool_row_serializer.md
Name: pool_row_serializer

Overview:
- Sits directly downstream of the max-pooling stage.
- Accepts one pooled row, (W/2)*D elements wide, per valid_i pulse and buffers whole rows in a small row FIFO.
- Emits the row one element per transfer over a valid/ready stream for the fully-connected stage.
- Flags the last element of each row and of each pooled frame ((H/2) rows).

Parameters:
DATA_BITS, 8, bits per element
D, 1, channels per pixel
H, 24, input feature-map height (pooled frame = H/2 rows)
W, 24, input feature-map width (pooled row = W/2 pixels)
FIFO_DEPTH, 2, row slots; power of two, >= 2

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
row_data_i  in  (W/2)*D*DATA_BITS  pooled row; element k at bits [k*DATA_BITS +: DATA_BITS]
valid_i  in  1  row_data_i valid this cycle (single-cycle pulse per row)
data_o  out  DATA_BITS  current element
valid_o  out  1  data_o valid
ready_i  in  1  consumer accepts data_o
row_last_o  out  1  data_o is element N-1 of its row
last_o  out  1  data_o is the final element of the frame
overflow_o  out  1  sticky: a row was dropped

Behaviour:
- Definitions:
  - N = (W/2)*D elements per row; R = H/2 rows per frame.
  - Transfer = valid_o & ready_i at a rising edge.
- Reset (asynchronous, takes effect immediately):
  - FIFO emptied; elem_cnt = 0, row_cnt = 0.
  - valid_o = 0, row_last_o = 0, last_o = 0, overflow_o = 0, data_o = 0.
  - Row storage contents are don't-care.
- State is implied by FIFO occupancy:
  - IDLE (empty): valid_o = 0.
  - STREAM (non-empty): valid_o = 1.
- data_o = head_row[elem_cnt*DATA_BITS +: DATA_BITS], muxed from registered storage; 0 when empty.
- Latency: a row pushed at edge t is presented (element 0) in cycle t+1. Sustained throughput is 1 element/cycle with ready_i = 1.
- Push: on valid_i, if not full, write row_data_i to the tail slot.
- Full and valid_i in the same cycle:
  - Accept if the head row's final element transfers that cycle, since the slot frees at the same edge.
  - Otherwise drop the row and set overflow_o = 1 until reset.
  - The maxpool stage has no backpressure, so dropping is the only option.
- Push into an empty FIFO: valid_o rises the next cycle, with no bubble beyond the 1-cycle latency.
- Per transfer:
  - elem_cnt increments.
  - At elem_cnt = N-1: elem_cnt -> 0, head pops, row_cnt increments.
  - At row_cnt = R-1 with elem_cnt = N-1: row_cnt wraps to 0.
- Flags (combinational from counters):
  - row_last_o = valid_o & (elem_cnt == N-1).
  - last_o = row_last_o & (row_cnt == R-1).
- Hold rule: while valid_o & !ready_i, data_o, row_last_o and last_o stay stable. valid_o never drops without a transfer, except on reset.
- Simultaneous push and pop never corrupt the head. Pointers are log2(FIFO_DEPTH) bits wide with natural wrap; an extra occupancy count of log2(FIFO_DEPTH)+1 bits distinguishes full from empty.
- Frame boundaries follow row count only. After an overflow drop the frame alignment is unreliable; overflow_o reports this.

Optional Feature:
- Macro: POOL_SER_FRAME_CNT_EN.
- Defined:
  - Adds output frame_cnt_o [15:0], reset to 0.
  - Increments on every transfer with last_o = 1 and wraps from 0xFFFF to 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package/header pool_pkg:
  - clog2 function.
  - ROW_ELEMS(W,D) = (W/2)*D and ROWS_PER_FRAME(H) = H/2 constants.
  - Element slice width macro.
- One sub-module, row_fifo:
  - Generic WIDTH/DEPTH register FIFO with push/pop/full/empty/head outputs.
  - Same-cycle push when full is allowed if pop is also asserted.
- Top level holds the counters, flags, overflow and output mux.

Test Plan:
- Reset: hold reset = 0 for 3 cycles -> valid_o = 0, data_o = 0, row_last_o = 0, last_o = 0, overflow_o = 0.
- Single row, defaults (N = 12): row elements 1..12 pushed at edge t, ready_i = 1 -> data_o = 1,2,...,12 on cycles t+1..t+12; row_last_o only with 12; valid_o = 0 at t+13.
- Backpressure: same row, ready_i = 0 for 4 cycles while data_o = 3 -> data_o held at 3 with valid_o = 1; resumes 4..12 with no loss or duplication.
- Overflow: ready_i = 0, push rows A, B, C on consecutive cycles -> C dropped, overflow_o = 1; later stream is A then B only. Repeat with C pushed on the final-element transfer of A -> accepted, overflow_o stays 0.
- Frame: 13 rows streamed with ready_i = 1 -> last_o exactly once, on transfer 144. Transfer 145 is element 0 of a new frame with row_cnt = 0; frame_cnt_o = 1 when POOL_SER_FRAME_CNT_EN is defined.
- Mid-row reset: assert reset while data_o = 5 -> valid_o = 0 immediately (asynchronous); after release, a new row streams from element 0 with row_cnt = 0.
